sync_bank: RTL and testbench

//   Multi-channel, parametrised bit synchroniser for the destination clock domain.

---
 rtl/sync_bank.sv | 85 ++++++++
 tb/tb_sync_bank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_bank.sv
// Multi-channel single-bit synchroniser: STAGES-deep flop chain per channel,
// optional stability filter, and registered rise/fall/edge pulses.
module sync_bank #(
    parameter int                NUM_CH     = 4,
    parameter int                STAGES     = 2,
    parameter int                FILTER_LEN = 0,
    parameter logic [NUM_CH-1:0] RST_VAL    = '0
) (
    input  logic              dst_clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] async_in,
    output logic [NUM_CH-1:0] sync_level,
    output logic [NUM_CH-1:0] sync_rise,
    output logic [NUM_CH-1:0] sync_fall,
    output logic [NUM_CH-1:0] sync_edge
);

    localparam int                N       = (FILTER_LEN < 1) ? 1 : FILTER_LEN;
    localparam int                CNT_W   = $clog2(N) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(N - 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_bank: STAGES must be at least 2");
        end
    endgenerate

    logic [NUM_CH-1:0] stage [STAGES];
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] next_level;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];

    // stage[0] is the only flop that may go metastable; stages are wired back to back.
    always_ff @(posedge dst_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign raw = stage[STAGES-1];

    // A channel's level only follows raw after N consecutive mismatching cycles.
    always_comb begin
        next_level = sync_level;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = '0;
            if (raw[c] != sync_level[c]) begin
                if (cnt_q[c] == CNT_MAX) begin
                    next_level[c] = raw[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge dst_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_level <= RST_VAL;
            sync_rise  <= '0;
            sync_fall  <= '0;
            sync_edge  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            sync_level <= next_level;
            sync_rise  <= next_level & ~sync_level;
            sync_fall  <= ~next_level & sync_level;
            sync_edge  <= next_level ^ sync_level;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

endmodule

// File: tb/tb_sync_bank.sv
// Bench for sync_bank: two configurations (unfiltered STAGES=2, filtered STAGES=3/N=4)
// checked every cycle against a history-window reference model plus directed cases.
module tb_sync_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ain_a, ain_b;
    logic [3:0] lvl_a, rise_a, fall_a, edge_a;
    logic [3:0] lvl_b, rise_b, fall_b, edge_b;

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;
    int  a2_edge = 0, a2_rise = 0, a2_fall = 0, b1_rise = 0;

    always #5 clk = ~clk;

    sync_bank #(.NUM_CH(4), .STAGES(2), .FILTER_LEN(0), .RST_VAL(4'b1010)) dut_a (
        .dst_clk(clk), .rst_n(rst_n), .async_in(ain_a),
        .sync_level(lvl_a), .sync_rise(rise_a), .sync_fall(fall_a), .sync_edge(edge_a)
    );

    sync_bank #(.NUM_CH(4), .STAGES(3), .FILTER_LEN(4), .RST_VAL(4'b0000)) dut_b (
        .dst_clk(clk), .rst_n(rst_n), .async_in(ain_b),
        .sync_level(lvl_b), .sync_rise(rise_b), .sync_fall(fall_b), .sync_edge(edge_b)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the level flips at edge e when the raw input seen at each of the
    // last N edges since reset differed from the level; raw at edge e is the
    // input sampled at edge e-S (reset value before that).
    for (genvar d = 0; d < 2; d++) begin : g_model
        localparam int         S  = (d == 0) ? 2 : 3;
        localparam int         N  = (d == 0) ? 1 : 4;
        localparam logic [3:0] RV = (d == 0) ? 4'b1010 : 4'b0000;
        logic [3:0] lvl, rise, fall, din;
        logic [3:0] hist [$];
        assign din = (d == 0) ? ain_a : ain_b;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist.delete();
                lvl  = RV;
                rise = 4'b0;
                fall = 4'b0;
            end else begin : step
                logic [3:0] nl;
                logic       ad, r;
                int         e, kk;
                hist.push_back(din);
                nl = lvl;
                for (int c = 0; c < 4; c++) begin
                    ad = 1'b1;
                    for (int j = 0; j < N; j++) begin
                        e  = hist.size() - j;
                        kk = e - S;
                        if (e < 1) begin
                            ad = 1'b0;
                        end else begin
                            r = (kk >= 1) ? hist[kk-1][c] : RV[c];
                            if (r == lvl[c]) ad = 1'b0;
                        end
                    end
                    if (ad) nl[c] = ~lvl[c];
                end
                rise = nl & ~lvl;
                fall = ~nl & lvl;
                lvl  = nl;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_level", 8'(lvl_a),  8'(g_model[0].lvl));
            check("a_rise",  8'(rise_a), 8'(g_model[0].rise));
            check("a_fall",  8'(fall_a), 8'(g_model[0].fall));
            check("a_edge",  8'(edge_a), 8'(g_model[0].rise | g_model[0].fall));
            check("b_level", 8'(lvl_b),  8'(g_model[1].lvl));
            check("b_rise",  8'(rise_b), 8'(g_model[1].rise));
            check("b_fall",  8'(fall_b), 8'(g_model[1].fall));
            check("b_edge",  8'(edge_b), 8'(g_model[1].rise | g_model[1].fall));
        end
        if (edge_a[2]) a2_edge++;
        if (rise_a[2]) a2_rise++;
        if (fall_a[2]) a2_fall++;
        if (rise_b[1]) b1_rise++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int lat, r0, e0, rr0, f0;
        rst_n = 1'b0;
        ain_a = 4'b0101;
        ain_b = 4'b0000;
        @(posedge clk);
        chk_en = 1'b1;

        // reset holds RST_VAL regardless of inputs
        cycles(3);
        check("rst_level_a", 8'(lvl_a), 8'h0a);
        check("rst_pulse_a", 8'(rise_a | fall_a | edge_a), 8'h00);
        check("rst_level_b", 8'(lvl_b), 8'h00);

        // release with inputs differing from RST_VAL: pulses at edge 3, none earlier
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("rel_rise_a", 8'(rise_a), (k == 3) ? 8'h05 : 8'h00);
            check("rel_fall_a", 8'(fall_a), (k == 3) ? 8'h0a : 8'h00);
        end
        #1;

        // ch0 0->1 on the unfiltered instance
        cycles(2);
        ain_a[0] = 1'b0;
        cycles(6);
        ain_a[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("t2_level0", 8'(lvl_a[0]),  8'(k >= 3));
            check("t2_rise0",  8'(rise_a[0]), 8'(k == 3));
            check("t2_edge0",  8'(edge_a[0]), 8'(k == 3));
        end
        #1;

        // filtered instance: 3-cycle excursion dropped, 4-cycle one accepted at edge 7
        r0 = b1_rise;
        ain_b[1] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        ain_b[1] = 1'b0;
        cycles(14);
        check("t3_short_lvl", 8'(lvl_b[1]), 8'h00);
        check("t3_short_rise", 8'(b1_rise - r0), 8'h00);
        r0 = b1_rise;
        lat = 0;
        ain_b[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && lvl_b[1]) lat = k;
            if (k == 4) ain_b[1] = 1'b0;
        end
        #1;
        check("t3_latency", 8'(lat), 8'd7);
        check("t3_rise_cnt", 8'(b1_rise - r0), 8'd1);

        // ch2 toggled every 3 cycles, 10 times, on the unfiltered instance
        e0 = a2_edge; rr0 = a2_rise; f0 = a2_fall;
        for (int i = 0; i < 10; i++) begin
            ain_a[2] = ~ain_a[2];
            cycles(3);
        end
        cycles(6);
        check("t4_edges", 8'(a2_edge - e0), 8'd10);
        check("t4_rises", 8'(a2_rise - rr0), 8'd5);
        check("t4_falls", 8'(a2_fall - f0), 8'd5);

        // all channels change together, mixed directions
        ain_a = 4'b0011;
        ain_b = 4'b1010;
        cycles(12);
        ain_a = 4'b1100;
        ain_b = 4'b0101;
        repeat (3) @(posedge clk);
        #1;
        check("t5_rise_a", 8'(rise_a), 8'h0c);
        check("t5_fall_a", 8'(fall_a), 8'h03);
        #1;
        cycles(12);

        // reset in the middle of a filter count, input still differing after release
        ain_b = 4'b0000;
        cycles(14);
        ain_b[0] = 1'b1;
        cycles(5);
        rst_n = 1'b0;
        cycles(3);
        check("t6_rst_level_b", 8'(lvl_b), 8'h00);
        check("t6_rst_pulse_b", 8'(rise_b | fall_b | edge_b), 8'h00);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && lvl_b[0]) lat = k;
        end
        #1;
        check("t6_latency", 8'(lat), 8'd7);

        // randomized traffic with occasional short resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) ain_a = 4'($urandom);
            if ($urandom_range(0, 5) == 0) ain_b = 4'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                cycles($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            cycles(1);
        end
        cycles(12);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
